// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader for the instruction memory.
//
// Frame format: len[7:0], len[15:8], len payload bytes, XOR checksum.
// Payload byte i is written to byte address i. The core is held in reset
// while a load is in progress.
//
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-high reset
//   start          - arm pulse, only looked at while idle
//   rx_data/valid  - incoming byte stream (valid/ready)
//   rx_ready       - high in every non-idle state
//   mem_we/addr/wdata - registered byte write port
//   busy/core_hold - load in progress (identical)
//   done/err       - sticky completion / abort flags, cleared by start
module prog_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM
    } state_t;

    state_t state, state_n;

    logic [15:0]     len;
    logic [ADDR_W:0] cnt;
    logic [7:0]      csum;
    logic [TW-1:0]   tcnt;

    logic        acc, tmo, len_big, last_byte, wr_byte;
    logic        set_done, set_err, arm;
    logic [15:0] full_len;

    assign rx_ready  = (state != S_IDLE);
    assign busy      = rx_ready;
    assign core_hold = busy;
    assign acc       = rx_valid && rx_ready;
    assign wr_byte   = (state == S_DATA) && acc;

    // Length as it will be once the high byte currently on rx_data lands.
    assign full_len  = {rx_data, len[7:0]};
    assign len_big   = 32'(full_len) > 32'(MEM_BYTES);
    // Counter is one bit wider than the address so len == MEM_BYTES ends cleanly.
    assign last_byte = (32'(cnt) + 32'd1) == 32'(len);
    // Fires on the TIMEOUT-th consecutive idle cycle since the last accepted byte.
    assign tmo       = (state != S_IDLE) && !acc && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        set_done = 1'b0;
        set_err  = 1'b0;
        arm      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    arm     = 1'b1;
                    state_n = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (acc) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (acc) begin
                    if (len_big) begin
                        set_err = 1'b1;
                        state_n = S_IDLE;
                    end else if (full_len == 16'd0) begin
                        state_n = S_CSUM;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc && last_byte) state_n = S_CSUM;
            end
            S_CSUM: begin
                if (acc) begin
                    if (rx_data == csum) set_done = 1'b1;
                    else                 set_err  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (tmo) begin
            set_err = 1'b1;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            cnt       <= '0;
            csum      <= '0;
            tcnt      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= wr_byte;
            if (wr_byte) begin
                mem_addr  <= cnt[ADDR_W-1:0];
                mem_wdata <= rx_data;
                cnt       <= cnt + 1'b1;
                csum      <= csum ^ rx_data;
            end
            if (state == S_LEN_LO && acc) len[7:0] <= rx_data;
            if (state == S_LEN_HI && acc) begin
                len[15:8] <= rx_data;
                cnt       <= '0;
            end
            if (state == S_IDLE || acc) tcnt <= '0;
            else                        tcnt <= tcnt + 1'b1;
            if (arm) begin
                done <= 1'b0;
                err  <= 1'b0;
                csum <= '0;
                len  <= '0;
                cnt  <= '0;
            end
            if (set_done) done <= 1'b1;
            if (set_err)  err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready, mem_we, busy, core_hold, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    prog_loader #(.MEM_BYTES(1024), .ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .core_hold(core_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write monitor: captures every write and checks address contiguity.
    logic [7:0]        tb_mem [0:1023];
    int                wr_cyc [0:2047];
    int                wr_n = 0;
    int                cyc  = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (start && !busy && !rst) wr_n = 0;
        if (mem_we) begin
            chk("addr_seq", 64'(mem_addr), 64'(wr_n % 1024));
            tb_mem[mem_addr] = mem_wdata;
            if (wr_n < 2048) wr_cyc[wr_n] = cyc;
            last_addr = mem_addr;
            wr_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present a byte and hold it until accepted; leaves rx_valid high.
    task automatic send(input logic [7:0] b);
        bit ok = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rx_ready) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) chk("send_bound", 0, 1);
    endtask

    task automatic send_stall(input logic [7:0] b);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
        send(b);
    endtask

    typedef struct {
        int          n;
        logic [63:0] bytes;   // first byte in [63:56]
        bit          exp_done;
        bit          exp_err;
        int          exp_wr;
    } vec_t;

    vec_t vt [0:7];

    function automatic logic [7:0] fb(input logic [63:0] v, input int k);
        return v[63-8*k -: 8];
    endfunction

    initial begin
        logic [7:0] cs;
        int         mm;

        vt[0] = '{7, 64'h0400_1305_A000_B600, 1, 0, 4};   // basic load
        vt[1] = '{7, 64'h0400_1305_A000_0000, 0, 1, 4};   // bad checksum
        vt[2] = '{2, 64'h0104_0000_0000_0000, 0, 1, 0};   // length 1025
        vt[3] = '{3, 64'h0000_0000_0000_0000, 1, 0, 0};   // zero length
        vt[4] = '{2, 64'hFFFF_0000_0000_0000, 0, 1, 0};   // length 65535
        vt[5] = '{3, 64'h0000_5A00_0000_0000, 0, 1, 0};   // zero length, bad csum
        vt[6] = '{5, 64'h0200_FF01_FE00_0000, 1, 0, 2};
        vt[7] = '{4, 64'h0100_8080_0000_0000, 1, 0, 1};

        // Reset state
        #3;
        chk("rst_ready", 64'(rx_ready), 0);
        chk("rst_we",    64'(mem_we), 0);
        chk("rst_addr",  64'(mem_addr), 0);
        chk("rst_wdata", 64'(mem_wdata), 0);
        chk("rst_busy",  64'({busy, core_hold}), 0);
        chk("rst_flags", 64'({done, err}), 0);
        step();
        rst = 1'b0;
        step();

        // Table-driven frames, bytes sent back to back
        for (int v = 0; v < 8; v++) begin
            do_start();
            chk($sformatf("v%0d_busy", v), 64'({busy, core_hold}), 64'b11);
            chk($sformatf("v%0d_clr", v), 64'({done, err}), 0);
            for (int k = 0; k < vt[v].n; k++) send(fb(vt[v].bytes, k));
            rx_valid = 1'b0;
            chk($sformatf("v%0d_flags", v), 64'({done, err, busy}),
                64'({vt[v].exp_done, vt[v].exp_err, 1'b0}));
            step();
            step();
            chk($sformatf("v%0d_nwr", v), 64'(wr_n), 64'(vt[v].exp_wr));
            for (int i = 0; i < vt[v].exp_wr && i < wr_n; i++)
                chk($sformatf("v%0d_mem%0d", v, i), 64'(tb_mem[i]), 64'(fb(vt[v].bytes, 2 + i)));
            if (vt[v].exp_wr > 1 && wr_n == vt[v].exp_wr)
                chk($sformatf("v%0d_b2b", v), 64'(wr_cyc[wr_n-1] - wr_cyc[0]), 64'(wr_n - 1));
        end

        // Maximum length: 1024 bytes
        do_start();
        send(8'h00);
        send(8'h04);
        cs = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            send(8'((i * 7 + 3) & 255));
            cs ^= 8'((i * 7 + 3) & 255);
        end
        send(cs);
        rx_valid = 1'b0;
        chk("max_flags", 64'({done, err, busy}), 64'b100);
        step();
        chk("max_nwr", 64'(wr_n), 1024);
        chk("max_last", 64'(last_addr), 64'h3FF);
        mm = 0;
        for (int i = 0; i < 1024; i++)
            if (tb_mem[i] !== 8'((i * 7 + 3) & 255)) mm++;
        chk("max_data", 64'(mm), 0);

        // Random rx_valid gaps during DATA
        do_start();
        send_stall(8'h08);
        send_stall(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_stall(8'(8'h31 + 8'(i * 16)));
            cs ^= 8'(8'h31 + 8'(i * 16));
        end
        send_stall(cs);
        rx_valid = 1'b0;
        chk("stall_flags", 64'({done, err}), 64'b10);
        step();
        chk("stall_nwr", 64'(wr_n), 8);
        mm = 0;
        for (int i = 0; i < 8; i++)
            if (tb_mem[i] !== 8'(8'h31 + 8'(i * 16))) mm++;
        chk("stall_data", 64'(mm), 0);

        // Timeout after 2 of 4 payload bytes
        do_start();
        send(8'h04);
        send(8'h00);
        send(8'hAA);
        send(8'hBB);
        rx_valid = 1'b0;
        repeat (15) step();
        chk("tmo_early", 64'({err, busy}), 64'b01);
        step();
        chk("tmo_err", 64'({done, err, busy, core_hold}), 64'b0100);
        chk("tmo_nwr", 64'(wr_n), 2);
        // Normal load afterwards
        do_start();
        for (int k = 0; k < vt[6].n; k++) send(fb(vt[6].bytes, k));
        rx_valid = 1'b0;
        chk("tmo_reload", 64'({done, err}), 64'b10);

        // start while busy is ignored
        do_start();
        send(8'h04);
        send(8'h00);
        send(8'h11);
        rx_valid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sbusy_state", 64'({busy, done, err}), 64'b100);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h44);
        rx_valid = 1'b0;
        chk("sbusy_done", 64'({done, err}), 64'b10);
        step();
        chk("sbusy_nwr", 64'(wr_n), 4);
        chk("sbusy_mem3", 64'(tb_mem[3]), 64'h44);

        // Reset in the middle of DATA
        do_start();
        send(8'h04);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        chk("mid_we", 64'({mem_we, busy}), 64'b11);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", 64'({rx_ready, mem_we, mem_addr, mem_wdata, busy, core_hold, done, err}), 0);
        rx_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_idle", 64'({rx_ready, busy, done, err}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the byte-addressed, little-endian instruction memory. It accepts a framed byte stream on a valid/ready input: a 16-bit length header, then the payload, then an XOR checksum. It writes each payload byte to consecutive memory byte addresses starting at 0 and holds the core in reset while loading. It sits between the UART receiver and the instruction memory's write port.

## Interface
- `MEM_BYTES`, default 1024: memory capacity in bytes; the largest legal length.
- `ADDR_W`, default 10: width of the byte address.
- `TIMEOUT`, default 1000000: maximum number of cycles between accepted bytes while busy.
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: arm pulse; sampled only in IDLE.
- `rx_data`, in, 8: incoming byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: loader can accept a byte.
- `mem_we`, out, 1: byte write strobe, registered.
- `mem_addr`, out, ADDR_W: byte address, registered.
- `mem_wdata`, out, 8: byte to write, registered.
- `busy`, out, 1: a load is in progress.
- `core_hold`, out, 1: holds the CPU in reset; equals `busy`.
- `done`, out, 1: sticky; load completed and checksum matched.
- `err`, out, 1: sticky; load aborted.

## Operation
- **Handshake:** a byte is accepted on any cycle with `rx_valid` and `rx_ready` both high. `rx_ready` is 1 in LEN_LO, LEN_HI, DATA and CSUM; it is 0 in IDLE.
- **States and transitions:**
  - IDLE: `start` clears `done` and `err`, clears the checksum, and goes to LEN_LO.
  - LEN_LO: an accepted byte becomes `len[7:0]`; go to LEN_HI.
  - LEN_HI: an accepted byte becomes `len[15:8]`.
    - If the full length exceeds `MEM_BYTES`: set `err` and go to IDLE; no memory writes occur.
    - If the length is 0: go to CSUM.
    - Otherwise: go to DATA with the byte counter at 0.
  - DATA: each accepted byte is written to address = byte counter, is XORed into the checksum, and increments the counter. After the byte that makes the counter reach `len`, go to CSUM.
  - CSUM: an accepted byte equal to the running checksum sets `done`; any other value sets `err`. Go to IDLE in both cases.
- `start` outside IDLE is ignored.
- **Timeout:** in any non-IDLE state, a cycle counter clears on every accepted byte. If the counter reaches `TIMEOUT` with no byte accepted, set `err` and go to IDLE. Memory bytes already written are left as they are.
- **Flags:** `done` and `err` are never both 1. Both stay unchanged until the next accepted `start` or `rst`.
- **Widths:**
  - The length is 16 bits and its comparison against `MEM_BYTES` is unsigned.
  - The byte counter is ADDR_W+1 bits, so a length of exactly `MEM_BYTES` completes without wrapping.
  - `mem_addr` is the low ADDR_W bits of the counter.
  - The checksum is 8-bit XOR over payload bytes only; header bytes are excluded.

## Timing
- **Reset values:** IDLE; `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `core_hold`=0, `done`=0, `err`=0. Length, counter, checksum and timeout counter are all 0.
- **Reset mid-load:** `rst` at any point returns everything to the reset values immediately. A partial image is left in memory and `done` stays 0.
- **`busy`:** rises the cycle after `start` is sampled in IDLE. It falls in the same cycle that `done` or `err` rises.
- **Write latency:** `mem_we` is high for exactly one cycle, the cycle after a DATA byte is accepted. In that cycle `mem_addr` and `mem_wdata` show that byte's address and value. Otherwise `mem_we`=0.
- **Throughput:** one byte per cycle is sustained when `rx_valid` is held high. Back-to-back DATA bytes give back-to-back `mem_we` pulses with the address incrementing by 1.
- **Flag latency:** `done` or `err` rises the cycle after the CSUM byte is accepted, or after the LEN_HI byte for an oversize length.
- **Order of the final byte:** the `mem_we` pulse for the last payload byte happens before the CSUM byte can be accepted.

## Test plan
- **Basic load:** `start`, then bytes 04 00 13 05 A0 00, then checksum B6 (13^05^A0^00) → writes 13@0, 05@1, A0@2, 00@3 on consecutive cycles; `done`=1, `err`=0, `busy`=0.
- **Bad checksum:** same frame with checksum 00 → four writes occur; `err`=1, `done`=0. A second `start` clears `err`.
- **Length limits:**
  - Header 01 04 (length 1025) → `err` on the cycle after LEN_HI and zero writes.
  - Header 00 04 (length 1024) followed by 1024 bytes → last write is at address 3FF; `done`=1 with the correct checksum.
- **Zero length and stalls:**
  - Header 00 00, checksum 00 → `done`=1 with no writes.
  - `rx_valid` toggled randomly during DATA → writes occur only after accepted bytes, and addresses stay contiguous.
- **Timeout (`TIMEOUT`=16):** stop sending after 2 of 4 payload bytes → `err` rises 16 cycles after the last accepted byte; `busy`=0; a later `start` loads normally.
- **Reset mid-DATA, plus `start` while busy:**
  - Assert `rst` mid-DATA → all outputs return to reset values immediately.
  - Pulse `start` while busy → no effect on state, counter or flags.
